// File: rtl/shift_seq_reg_if.sv
// Bus bundle for shift_seq_reg: command side (load, start, shift setup,
// serial input) and status side (register contents, serial output, busy, done).
interface shift_seq_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             ld;
    logic [WIDTH-1:0] d_in;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    // Host / control FSM side.
    modport master (
        output ld, d_in, start, dir, mode, count, ser_in,
        input  q, ser_out, busy, done
    );

    // Shift register side.
    modport slave (
        input  ld, d_in, start, dir, mode, count, ser_in,
        output q, ser_out, busy, done
    );
endinterface

// File: rtl/shift_seq_reg.sv
// Sequenced WIDTH-bit shift register. A start command latches direction,
// mode and count, then the block shifts one bit per clock until the count
// is exhausted and raises done for one cycle. Modes: logical, arithmetic,
// rotate and serial-in. Parallel load is accepted only when not shifting.
module shift_seq_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    shift_seq_reg_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             dir_r;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] q_r;
    logic             ser_r;
    logic             accept_ld;
    logic             accept_start;
    logic             shift_en;
    logic [WIDTH:0]   shifted;

    // One single-bit shift step. Result is {bit shifted out, new register}.
    // Rotate fills with the outgoing bit; arithmetic only sign-fills on right.
    function automatic logic [WIDTH:0] shift_one(
        input logic [WIDTH-1:0] v,
        input logic             right,
        input logic [1:0]       md,
        input logic             sin
    );
        logic out_bit;
        logic fill;
        out_bit = right ? v[0] : v[WIDTH-1];
        case (md)
            2'b00:   fill = 1'b0;
            2'b01:   fill = right ? v[WIDTH-1] : 1'b0;
            2'b10:   fill = out_bit;
            default: fill = sin;
        endcase
        if (right) begin
            return {out_bit, fill, v[WIDTH-1:1]};
        end
        return {out_bit, v[WIDTH-2:0], fill};
    endfunction

    assign shifted = shift_one(q_r, dir_r, mode_r, bus.ser_in);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; IDLE and DONE accept commands the same way, ld wins over start.
    always_comb begin
        state_next   = state;
        accept_ld    = 1'b0;
        accept_start = 1'b0;
        shift_en     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.ld) begin
                    accept_ld  = 1'b1;
                    state_next = IDLE;
                end else if (bus.start) begin
                    if (bus.count != '0) begin
                        accept_start = 1'b1;
                        state_next   = SHIFT;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (rem == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched shift setup and remaining-count down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_r  <= 1'b0;
            mode_r <= 2'b00;
            rem    <= '0;
        end else if (accept_start) begin
            dir_r  <= bus.dir;
            mode_r <= bus.mode;
            rem    <= bus.count;
        end else if (shift_en) begin
            rem <= rem - CNT_W'(1);
        end
    end

    // Register contents and serial output; ser_out only moves on shift edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r   <= '0;
            ser_r <= 1'b0;
        end else if (accept_ld) begin
            q_r <= bus.d_in;
        end else if (shift_en) begin
            ser_r <= shifted[WIDTH];
            q_r   <= shifted[WIDTH-1:0];
        end
    end

    assign bus.q       = q_r;
    assign bus.ser_out = ser_r;
    assign bus.busy    = (state == SHIFT);
    assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_shift_seq_reg.sv
// Directed bench for shift_seq_reg (WIDTH=8, CNT_W=4). Stimulus pushes the
// hand-computed expected register value after every shift step, and the
// expected final state of each sequence, into queues; a monitor on the
// falling edge pops and compares whenever a shift has just happened or
// done is presented.
module tb_shift_seq_reg;
    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [7:0] q;
        logic       ser;
        int         nbusy;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shift_seq_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_seq_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [8:0] step_q[$];
    done_t      done_q[$];
    bit         mon_en = 1'b0;
    logic       prev_busy = 1'b0;
    logic       prev_done = 1'b0;
    int         bcnt = 0;
    logic [8:0] se;
    done_t      de;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a busy cycle means the following edge shifted.
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
            bcnt      = 0;
        end else begin
            if (prev_busy) begin
                if (step_q.size() == 0) begin
                    chk("unexpected_shift", 32'(step_q.size()), 32'd1);
                end else begin
                    se = step_q.pop_front();
                    chk("step_q", 32'(bus.q), 32'(se[7:0]));
                    chk("step_ser_out", 32'(bus.ser_out), 32'(se[8]));
                end
            end
            if (bus.busy) bcnt++;
            if (bus.done) begin
                chk("done_one_cycle", 32'(prev_done), 32'd0);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(done_q.size()), 32'd1);
                end else begin
                    de = done_q.pop_front();
                    chk("final_q", 32'(bus.q), 32'(de.q));
                    chk("final_ser_out", 32'(bus.ser_out), 32'(de.ser));
                    chk("busy_cycles", 32'(bcnt), 32'(de.nbusy));
                end
                bcnt = 0;
            end
            prev_busy = bus.busy;
            prev_done = bus.done;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        bus.d_in = v;
        bus.ld   = 1'b1;
        cyc();
        bus.ld   = 1'b0;
    endtask

    task automatic go(input logic dr, input logic [1:0] md, input logic [3:0] cnt);
        bus.dir   = dr;
        bus.mode  = md;
        bus.count = cnt;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic push_step(input logic [7:0] v, input logic s);
        step_q.push_back({s, v});
    endtask

    task automatic push_done(input logic [7:0] v, input logic s, input int n);
        done_t t;
        t.q     = v;
        t.ser   = s;
        t.nbusy = n;
        done_q.push_back(t);
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (step_q.size() == 0 && done_q.size() == 0) break;
            cyc();
        end
        chk("drain_timeout", 32'(step_q.size() + done_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sbits;
        bus.ld = 1'b0; bus.d_in = '0; bus.start = 1'b0; bus.dir = 1'b0;
        bus.mode = 2'b00; bus.count = '0; bus.ser_in = 1'b0;

        // Reset state
        #3 rst = 1'b1;
        #1;
        chk("reset_q", 32'(bus.q), 32'h00);
        chk("reset_ser_out", 32'(bus.ser_out), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        mon_en = 1'b1;

        // Arithmetic right by 3 on 0x96
        load(8'h96);
        chk("load_q", 32'(bus.q), 32'h96);
        push_step(8'hCB, 1'b0); push_step(8'hE5, 1'b1); push_step(8'hF2, 1'b1);
        push_done(8'hF2, 1'b1, 3);
        go(1'b1, 2'b01, 4'd3);
        drain();

        // Logical left by 2, then rotate left by 4 started in the done cycle
        load(8'h96);
        push_step(8'h2C, 1'b1); push_step(8'h58, 1'b0);
        push_done(8'h58, 1'b0, 2);
        push_step(8'hB0, 1'b0); push_step(8'h61, 1'b1);
        push_step(8'hC2, 1'b0); push_step(8'h85, 1'b1);
        push_done(8'h85, 1'b1, 4);
        go(1'b0, 2'b00, 4'd2);
        cyc(); cyc();
        chk("b2b_in_done_cycle", 32'(bus.done), 32'd1);
        go(1'b0, 2'b10, 4'd4);
        chk("b2b_accepted_busy", 32'(bus.busy), 32'd1);
        drain();

        // Serial-in right by 8, ser_in = 1,0,1,1,0,0,1,0
        load(8'h00);
        sbits = 8'b0100_1101;
        push_step(8'h80, 1'b0); push_step(8'h40, 1'b0); push_step(8'hA0, 1'b0);
        push_step(8'hD0, 1'b0); push_step(8'h68, 1'b0); push_step(8'h34, 1'b0);
        push_step(8'h9A, 1'b0); push_step(8'h4D, 1'b0);
        push_done(8'h4D, 1'b0, 8);
        go(1'b1, 2'b11, 4'd8);
        for (int i = 0; i < 8; i++) begin
            bus.ser_in = sbits[i];
            cyc();
        end
        bus.ser_in = 1'b0;
        drain();

        // ld and start together in IDLE: load wins, no sequence
        bus.d_in = 8'h3C; bus.count = 4'd3; bus.dir = 1'b0; bus.mode = 2'b00;
        bus.ld = 1'b1; bus.start = 1'b1;
        cyc();
        bus.ld = 1'b0; bus.start = 1'b0;
        cyc(); cyc(); cyc();
        chk("ld_start_q", 32'(bus.q), 32'h3C);
        chk("ld_start_busy", 32'(bus.busy), 32'd0);
        chk("ld_keeps_ser_out", 32'(bus.ser_out), 32'd0);

        // ld and start mid-shift are ignored (logical right by 3 on 0x96)
        load(8'h96);
        push_step(8'h4B, 1'b0); push_step(8'h25, 1'b1); push_step(8'h12, 1'b1);
        push_done(8'h12, 1'b1, 3);
        go(1'b1, 2'b00, 4'd3);
        bus.d_in = 8'hFF; bus.ld = 1'b1; bus.start = 1'b1;
        bus.dir = 1'b0; bus.mode = 2'b10; bus.count = 4'd5;
        cyc();
        bus.ld = 1'b0; bus.start = 1'b0;
        drain();

        // count = 0: done only, q and ser_out unchanged
        push_done(8'h12, 1'b1, 0);
        go(1'b0, 2'b00, 4'd0);
        chk("cnt0_busy_low", 32'(bus.busy), 32'd0);
        drain();
        chk("cnt0_q_after", 32'(bus.q), 32'h12);

        // Rotate left by 9 on 0x96 equals rotate by 1
        load(8'h96);
        push_step(8'h2D, 1'b1); push_step(8'h5A, 1'b0); push_step(8'hB4, 1'b0);
        push_step(8'h69, 1'b1); push_step(8'hD2, 1'b0); push_step(8'hA5, 1'b1);
        push_step(8'h4B, 1'b1); push_step(8'h96, 1'b0); push_step(8'h2D, 1'b1);
        push_done(8'h2D, 1'b1, 9);
        go(1'b0, 2'b10, 4'd9);
        drain();

        // Asynchronous reset mid-sequence with q = 0xA5
        mon_en = 1'b0;
        load(8'hA5);
        go(1'b1, 2'b00, 4'd10);
        cyc();
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_q", 32'(bus.q), 32'h00);
        chk("async_reset_ser_out", 32'(bus.ser_out), 32'd0);
        chk("async_reset_busy", 32'(bus.busy), 32'd0);
        chk("async_reset_done", 32'(bus.done), 32'd0);
        cyc();
        rst = 1'b0;
        mon_en = 1'b1;
        cyc();
        chk("post_reset_busy", 32'(bus.busy), 32'd0);
        chk("post_reset_done", 32'(bus.done), 32'd0);
        load(8'h81);
        push_step(8'h02, 1'b1);
        push_done(8'h02, 1'b1, 1);
        go(1'b0, 2'b00, 4'd1);
        drain();

        cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_seq_reg.md
# shift_seq_reg

Parametrised sequenced shift register. It extends the team's 4-bit load/shift-left/shift-right register to WIDTH bits and adds logical, arithmetic, rotate and serial-in modes. A start/busy/done handshake makes the block shift by a programmed count, one bit per clock, without per-cycle control from the host. It sits between a control FSM and datapath registers, and serves as a serialiser or a multi-cycle shifter.

## Interface
- WIDTH, default 8: register width, ≥2.
- CNT_W, default 4: width of the shift-count input. Counts 0..2^CNT_W-1.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: reset rst, asynchronous, active-high.
- ld  in  1: parallel load request.
- d_in  in  WIDTH: parallel load data.
- start  in  1: begin a shift sequence.
- dir  in  1: 0 = left (toward MSB), 1 = right. Sampled with start.
- mode  in  2: sampled with start.
  - 00 logical, zero fill.
  - 01 arithmetic. Right: sign fill. Left: identical to logical.
  - 10 rotate.
  - 11 serial-in, ser_in fill.
- count  in  CNT_W: number of single-bit shifts. Sampled with start.
- ser_in  in  1: fill bit for mode 11. Sampled on every shift edge.
- q  out  WIDTH: register contents.
- ser_out  out  1: bit shifted out by the most recent shift. For rotate, this is the bit that wrapped.
- busy  out  1: a sequence is shifting.
- done  out  1: one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (any time, including mid-sequence):
  - q = 0, ser_out = 0, busy = 0, done = 0.
  - State = IDLE. The latched dir, mode and remaining count are cleared.
- IDLE and DONE accept commands identically:
  - ld = 1: q ← d_in. ld has priority, so a simultaneous start is ignored (dropped, not queued). The next state is IDLE.
  - start = 1, ld = 0, count > 0: latch dir, mode and count into rem. Next state is SHIFT. q is unchanged on this edge.
  - start = 1, ld = 0, count = 0: next state is DONE. No shift occurs and q is unchanged.
  - Otherwise, the next state is IDLE.
- SHIFT, on each edge:
  - Perform one shift using the latched dir and mode, then rem ← rem-1.
  - If rem was 1, the next state is DONE. Otherwise stay in SHIFT.
  - ld and start are ignored while in SHIFT.
- Shift definitions:
  - Left: q ← {q[W-2:0], f}, ser_out ← q[W-1].
  - Right: q ← {f, q[W-1:1]}, ser_out ← q[0].
  - Fill bit f:
    - mode 00: 0.
    - mode 01: q[W-1] for right, 0 for left.
    - mode 10: the bit shifted out (wraps around).
    - mode 11: ser_in.
- Counts above WIDTH are legal:
  - Logical and arithmetic shifts saturate to all-zero or all-sign.
  - Rotate by k is equivalent to rotate by k mod WIDTH.
- ser_out updates only on shift edges. It holds otherwise, including across loads.

## Timing
- busy = (state == SHIFT). done = (state == DONE). Both are registered-state decodes and glitch-free.
- For start accepted at edge k with count N > 0:
  - q changes at edges k+1 through k+N.
  - busy is high from edge k to edge k+N.
  - done is high for the single cycle between edges k+N and k+N+1.
- For count = 0: done is high for the single cycle after edge k, and busy stays low.
- Back-to-back sequences: a start asserted during the done cycle is accepted at edge k+N+1, with no idle gap.
- ld latency: 1 edge. It is blocked while busy.

## Test plan
- Reset with q = 0xA5 while in SHIFT:
  - q = 0x00 immediately, busy = 0, done = 0.
  - After release, the state is IDLE and start works normally.
- WIDTH = 8, load 0x96, start dir = 1, mode 01, count 3:
  - busy is high for 3 cycles.
  - q steps 0xCB, 0xE5, 0xF2.
  - done pulses once. ser_out = 1.
- Load 0x96, dir = 0, mode 00, count 2:
  - q steps 0x2C, 0x58. ser_out = 0.
  - Then start dir = 0, mode 10, count 4 during the done cycle: accepted with no gap, final q = 0x85.
- Load 0x00, dir = 1, mode 11, count 8, ser_in sequence 1,0,1,1,0,0,1,0: final q = 0x4D.
- ld = 1 with start = 1 in IDLE: q = d_in and no sequence starts. ld and start mid-SHIFT: both are ignored and the shift result is unaffected.
- count = 0 start:
  - done is high for 1 cycle, busy is never high, and q is unchanged.
  - Also: rotate count 9 on 0x96 left gives 0x2D.
